// File: rtl/iic_pkg.sv
// -----------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the TRSQ8 I2C blocks (iic_core initiator and
// iic_target responder): bus widths and the target FSM state encoding.
// No ports.
// -----------------------------------------------------------------------------
package iic_pkg;

    localparam int IIC_BYTE_W = 8;
    localparam int IIC_ADDR_W = 7;

    // S_ prefix keeps the state names clear of the ADDR parameter.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WR_ACK,
        S_READ,
        S_RD_ACK
    } iic_state_e;

endpackage

// File: rtl/iic_line_filter.sv
// -----------------------------------------------------------------------------
// iic_line_filter
// Brings one asynchronous bus line into the clock domain and de-glitches it.
// A 2-FF synchroniser is followed by a stability filter: the filtered level
// only changes after the synchronised line has held a new value for
// FILTER_LEN consecutive cycles. Rise/fall pulses are one cycle wide and
// coincide with the cycle in which the filtered level takes its new value.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous reset, active-high (line assumed idle-high)
//   line_in  in  raw asynchronous line
//   level    out filtered level
//   rise     out one-cycle pulse on a filtered 0->1 transition
//   fall     out one-cycle pulse on a filtered 1->0 transition
// -----------------------------------------------------------------------------
module iic_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, regardless of the order
    // of statements in the block.
    always_ff @(posedge clock) begin
        if (reset) begin
            // An idle I2C bus is pulled high, so resetting to 1 avoids a
            // spurious edge when reset is released on a quiet bus.
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_target.sv
// -----------------------------------------------------------------------------
// iic_target
// I2C target (slave) for the TRSQ8 peripheral bus. Oversamples SCL/SDA on the
// system clock, detects START / repeated START / STOP, matches a 7-bit
// address, ACKs it, delivers written bytes to the host and fetches read bytes
// from it. Open-drain SDA, no clock stretching.
// Ports:
//   clock     in    system clock
//   reset     in    synchronous reset, active-high
//   scl       in    bus clock
//   sda       inout bus data, open-drain (driven low or released)
//   rx_data   out   last byte written by the initiator
//   rx_valid  out   one-cycle pulse: rx_data updated
//   tx_data   in    byte to return on a read, captured when tx_req pulses
//   tx_req    out   one-cycle pulse: tx_data captured, host presents next
//   rw        out   R/W bit of the current transfer (1 = read)
//   busy      out   high from an address match until STOP, NACK or mismatch
// -----------------------------------------------------------------------------
module iic_target
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] ADDR       = 7'h50,
    parameter int                    FILTER_LEN = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [IIC_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [IIC_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  rw,
    output logic                  busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (scl),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clock   (clock),
        .reset   (reset),
        .line_in (sda),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    iic_state_e            state;
    logic [2:0]            bit_cnt;
    // Only 7 bits are stored: the 8th bit is taken straight from the line
    // when a received byte completes, and bit 7 of a transmitted byte is
    // driven straight from tx_data when it is loaded.
    logic [IIC_BYTE_W-2:0] shift_q;
    logic                  sda_oe;
    // In ADDR_ACK/WR_ACK: ACK is being driven. In RD_ACK: initiator ACKed.
    logic                  ack_phase;

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_q   <= '0;
            sda_oe    <= 1'b0;
            ack_phase <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            // START/STOP take priority over any scl edge in the same cycle;
            // a partially shifted byte is simply abandoned.
            if (start_det) begin
                state     <= S_ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
            end else if (stop_det) begin
                state     <= S_IDLE;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_ADDR: if (scl_rise) begin
                        shift_q <= {shift_q[IIC_BYTE_W-3:0], sda_lvl};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            if (shift_q == ADDR) begin
                                rw        <= sda_lvl;
                                busy      <= 1'b1;
                                ack_phase <= 1'b0;
                                state     <= S_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            if (rw) begin
                                shift_q <= tx_data[IIC_BYTE_W-2:0];
                                tx_req  <= 1'b1;
                                sda_oe  <= ~tx_data[IIC_BYTE_W-1];
                                state   <= S_READ;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: if (scl_rise) begin
                        shift_q <= {shift_q[IIC_BYTE_W-3:0], sda_lvl};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_data   <= {shift_q, sda_lvl};
                            rx_valid  <= 1'b1;
                            ack_phase <= 1'b0;
                            state     <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= S_WRITE;
                        end
                    end
                    S_READ: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe    <= 1'b0;
                            bit_cnt   <= '0;
                            ack_phase <= 1'b0;
                            state     <= S_RD_ACK;
                        end else begin
                            sda_oe  <= ~shift_q[IIC_BYTE_W-2];
                            shift_q <= {shift_q[IIC_BYTE_W-3:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end else if (scl_fall && ack_phase) begin
                            shift_q   <= tx_data[IIC_BYTE_W-2:0];
                            tx_req    <= 1'b1;
                            sda_oe    <= ~tx_data[IIC_BYTE_W-1];
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= S_READ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
